mem_access_stage: RTL
=====================

// Module: mem_access_stage
// PURPOSE
//  Downstream of the data-movement decode stage: consumes its read/write codes, mem_addr and y.
//  Runs the data-memory req/ack handshake for LDW/STW/PUSH/POP, then writes the register file.
//  Also produces the stack-pointer update for PUSH/POP.
//  Single outstanding operation; busy back-pressures the issuing stage.
// PARAMETERS
//  DATA_W          32  data and address width
//  STACK_STEP      4   byte step applied to rsp by PUSH/POP
//  TIMEOUT_CYCLES  16  max cycles waiting for mem_ack (only with MEM_TIMEOUT_EN)
// PORTS
//  clk        in   1       clock; all logic rising-edge
//  rst_n      in   1       synchronous, active-low reset
//  start      in   1       operation valid; accepted only when busy==0
//  opcode     in   5       LDW=00001 STW=00010 MV=00011 PUSH=10011 POP=10100
//  read       in   2       01 memory, 10 regs, 00 nothing
//  write      in   2       01 memory, 10 regs, 00 nothing
//  addr_in    in   DATA_W  memory address (rsp for PUSH/POP)
//  wdata_in   in   DATA_W  y from upstream: store data or register write data
//  rd_idx     in   5       destination register index
//  busy       out  1       operation in flight
//  done       out  1       one-cycle pulse: operation complete
//  mem_req    out  1       memory request; held until mem_ack
//  mem_we     out  1       1 write, 0 read; valid while mem_req
//  mem_addr   out  DATA_W  effective address; stable while mem_req
//  mem_wdata  out  DATA_W  store data; stable while mem_req
//  mem_rdata  in   DATA_W  load data; sampled in the mem_ack cycle
//  mem_ack    in   1       memory completion; ignored when mem_req==0
//  rf_we      out  1       register-file write strobe (one cycle)
//  rf_waddr   out  5       register-file write index
//  rf_wdata   out  DATA_W  register-file write data
//  rsp_we     out  1       stack-pointer write strobe (one cycle, with done)
//  rsp_next   out  DATA_W  new rsp value
//  err        out  1       timeout flag, sticky until reset (only with MEM_TIMEOUT_EN)
// BEHAVIOUR
//  Reset: state IDLE. All outputs 0: busy, done, mem_req, mem_we, mem_addr, mem_wdata, rf_*, rsp_*, err.
//   rst_n low mid-operation drops mem_req on the next edge; any late mem_ack is ignored.
//  FSM states: IDLE, MEM_REQ, WB, FIN.
//  IDLE + start: latch opcode, read, write, addr, wdata, rd_idx; busy=1 from the next cycle.
//  Path selection:
//   - write==01: go to MEM_REQ, mem_we=1.
//   - read==01 and write==10: go to MEM_REQ, mem_we=0.
//   - write==10, read!=01 (MV): go to WB.
//   - anything else, including codes 11: go to FIN. No side effects.
//  Effective address:
//   - PUSH: addr_in. rsp_next = addr_in - STACK_STEP.
//   - POP: addr_in + STACK_STEP. rsp_next = addr_in + STACK_STEP.
//   - all others: addr_in.
//   - Modulo 2^DATA_W arithmetic; wrap-around is not flagged.
//  MEM_REQ: mem_req=1 until the cycle mem_ack=1.
//   - mem_ack in the same cycle as the first mem_req assertion counts as accepted.
//   - Write: go to FIN.
//   - Read: capture mem_rdata, then go to WB.
//  WB: rf_we=1 for one cycle. rf_waddr=rd_idx. rf_wdata = loaded data, or latched wdata for MV. Go to FIN.
//  FIN: done=1 for one cycle; rsp_we=1 this cycle if PUSH/POP. busy=0 next cycle; back to IDLE.
//  Latency: start at cycle N.
//   - MV: rf_we at N+2, done at N+3.
//   - Store/PUSH: mem_req from N+1; done one cycle after ack.
//   - Load/POP: rf_we one cycle after ack; done the cycle after that.
//  start while busy: ignored (not queued).
//  start in the FIN cycle: ignored; accepted from IDLE only.
// CONFIGURATION
//  MEM_TIMEOUT_EN defined:
//   - Counter runs while in MEM_REQ.
//   - TIMEOUT_CYCLES cycles without ack: drop mem_req, set err, skip WB, go to FIN.
//     done pulses; no rf_we, no rsp_we.
//  MEM_TIMEOUT_EN undefined: no counter; waits forever for ack; err tied 0.
// STRUCTURE
//  Shared include cpu_defs.vh holds:
//   - opcode localparams (LDW, STW, MV, PUSH, POP)
//   - REGS/MEMORY/NOTHING codes
//   - FSM state encodings
//  One sub-module: mem_watchdog (timeout counter), instantiated only under MEM_TIMEOUT_EN.
// TESTING
//  - MV, wdata_in=0x1234, rd_idx=3 -> rf_we at N+2 with rf_waddr=3, rf_wdata=0x1234; done at N+3; no mem_req.
//  - STW addr=0x100, wdata=0xDEAD, ack after 3 wait cycles -> mem_req/mem_we=1 stable 4 cycles; done 1 cycle after ack.
//  - LDW addr=0x40, mem_rdata=0xCAFE with 0-wait ack -> rf_wdata=0xCAFE; rf_we then done on consecutive cycles.
//  - PUSH addr=0x1000 -> mem_addr=0x1000, rsp_next=0xFFC.
//    POP addr=0xFFC -> mem_addr=0x1000, rsp_next=0x1000. rsp_we with done.
//  - Second start while busy, then rst_n low in MEM_REQ -> second start ignored; mem_req=0 after the edge; late ack ignored.
//  - With MEM_TIMEOUT_EN and no ack -> mem_req drops after 16 cycles; err=1, done=1, no rf_we.

Source files
------------

// File: rtl/mem_access_stage_pkg.sv
// Shared opcode, read/write code and FSM/path encodings for mem_access_stage.
package mem_access_stage_pkg;

  localparam logic [4:0] OP_LDW  = 5'b00001;
  localparam logic [4:0] OP_STW  = 5'b00010;
  localparam logic [4:0] OP_MV   = 5'b00011;
  localparam logic [4:0] OP_PUSH = 5'b10011;
  localparam logic [4:0] OP_POP  = 5'b10100;

  localparam logic [1:0] CODE_NOTHING = 2'b00;
  localparam logic [1:0] CODE_MEMORY  = 2'b01;
  localparam logic [1:0] CODE_REGS    = 2'b10;

  typedef enum logic [1:0] {ST_IDLE, ST_MEM_REQ, ST_WB, ST_FIN} state_t;
  typedef enum logic [1:0] {PATH_NONE, PATH_MV, PATH_STORE, PATH_LOAD} path_t;

  // Memory write wins over everything; undefined code 11 falls through to no-op.
  function automatic path_t decode_path(input logic [1:0] read, input logic [1:0] write);
    if (write == CODE_MEMORY) return PATH_STORE;
    if (read == CODE_MEMORY && write == CODE_REGS) return PATH_LOAD;
    if (write == CODE_REGS) return PATH_MV;
    return PATH_NONE;
  endfunction

  function automatic logic is_stack_op(input logic [4:0] opcode);
    return (opcode == OP_PUSH) || (opcode == OP_POP);
  endfunction

endpackage

// File: rtl/mem_watchdog.sv
// Counts consecutive cycles with run high; expire fires in the TIMEOUT_CYCLES-th one, no backpressure.
// Compiled only with MEM_TIMEOUT_EN, which is the sole build that instantiates it.
`ifdef MEM_TIMEOUT_EN
module mem_watchdog #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

  logic [CW-1:0] count;

  assign expire = run && (count == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (run) begin
      count <= count + CW'(1);
    end else begin
      count <= '0;
    end
  end

endmodule
`endif

// File: rtl/mem_access_stage.sv
// Data-memory stage: req/ack handshake for LDW/STW/PUSH/POP, register write-back, rsp update; one op in flight.
// MV done at N+3, stores done 1 cycle after ack, loads 2; busy stalls issue. MEM_TIMEOUT_EN adds an ack watchdog.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int STACK_STEP     = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [4:0]        opcode,
  input  logic [1:0]        read,
  input  logic [1:0]        write,
  input  logic [DATA_W-1:0] addr_in,
  input  logic [DATA_W-1:0] wdata_in,
  input  logic [4:0]        rd_idx,
  output logic              busy,
  output logic              done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              rf_we,
  output logic [4:0]        rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              rsp_we,
  output logic [DATA_W-1:0] rsp_next,
  output logic              err
);

  localparam logic [DATA_W-1:0] STEP = DATA_W'(STACK_STEP);

  state_t            state;
  path_t             path;
  logic              stack_op;
  logic              timeout;
  logic [DATA_W-1:0] eff_addr;
  logic [DATA_W-1:0] rsp_calc;

  assign path = decode_path(read, write);

  always_comb begin
    eff_addr = addr_in;
    rsp_calc = addr_in;
    if (opcode == OP_POP) begin
      eff_addr = addr_in + STEP;
      rsp_calc = addr_in + STEP;
    end else if (opcode == OP_PUSH) begin
      rsp_calc = addr_in - STEP;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rf_we     <= 1'b0;
      rf_waddr  <= '0;
      rf_wdata  <= '0;
      rsp_we    <= 1'b0;
      rsp_next  <= '0;
      stack_op  <= 1'b0;
    end else begin
      done   <= 1'b0;
      rf_we  <= 1'b0;
      rsp_we <= 1'b0;
      case (state)
        ST_IDLE: if (start) begin
          busy      <= 1'b1;
          mem_addr  <= eff_addr;
          mem_wdata <= wdata_in;
          rf_waddr  <= rd_idx;
          stack_op  <= is_stack_op(opcode) && (path == PATH_STORE || path == PATH_LOAD);
          if (is_stack_op(opcode) && (path == PATH_STORE || path == PATH_LOAD)) begin
            rsp_next <= rsp_calc;
          end
          case (path)
            PATH_STORE: begin
              mem_req <= 1'b1;
              mem_we  <= 1'b1;
              state   <= ST_MEM_REQ;
            end
            PATH_LOAD: begin
              mem_req <= 1'b1;
              mem_we  <= 1'b0;
              state   <= ST_MEM_REQ;
            end
            PATH_MV: state <= ST_WB;
            default: begin
              done  <= 1'b1;
              state <= ST_FIN;
            end
          endcase
        end
        ST_MEM_REQ: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            if (mem_we) begin
              done   <= 1'b1;
              rsp_we <= stack_op;
              state  <= ST_FIN;
            end else begin
              rf_we    <= 1'b1;
              rf_wdata <= mem_rdata;
              state    <= ST_WB;
            end
          end else if (timeout) begin
            mem_req <= 1'b0;
            done    <= 1'b1;
            state   <= ST_FIN;
          end
        end
        // Loads arrive with rf_we already up; MV spends its first WB cycle staging the data.
        ST_WB: begin
          if (rf_we) begin
            done   <= 1'b1;
            rsp_we <= stack_op;
            state  <= ST_FIN;
          end else begin
            rf_we    <= 1'b1;
            rf_wdata <= mem_wdata;
          end
        end
        ST_FIN: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef MEM_TIMEOUT_EN
  mem_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (state == ST_MEM_REQ),
    .expire(timeout)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (state == ST_MEM_REQ && !mem_ack && timeout) begin
      err <= 1'b1;
    end
  end
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

endmodule
